// File: rtl/addr_counter_pkg.sv
// Shared types and default constants for the address counter.
package addr_counter_pkg;

  // Counting direction as carried on the up port.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int ADDR_W_DEFAULT = 5;
  localparam int STEP_DEFAULT   = 1;

endpackage

// File: rtl/addr_counter_step.sv
// Combinational next-count logic for addr_counter.
// Computes the stepped value and whether the step crossed the 0..MAX range
// boundary. With ADDR_COUNTER_SAT_EN defined the value clips to MAX/0
// instead of wrapping modulo MAX+1.
module addr_counter_step
  import addr_counter_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEFAULT,
  parameter int MAX   = 2**WIDTH - 1,
  parameter int STEP  = STEP_DEFAULT
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             crossed
);

  // One guard bit so cur + STEP and cur + MAX + 1 never overflow.
  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_W  = MAX_W + 1'b1;

  logic [WIDTH:0] cur_w;
  logic [WIDTH:0] sum_w;

  // Step in the requested direction, correcting at the range boundary.
  always_comb begin
    cur_w   = {1'b0, cur};
    sum_w   = cur_w + STEP_W;
    nxt     = cur;
    crossed = 1'b0;
    if (dir_e'(up) == DIR_UP) begin
      if (sum_w <= MAX_W) begin
        nxt = WIDTH'(sum_w);
      end else begin
        crossed = 1'b1;
`ifdef ADDR_COUNTER_SAT_EN
        nxt = WIDTH'(MAX_W);
`else
        nxt = WIDTH'(sum_w - MOD_W);
`endif
      end
    end else begin
      if (cur_w >= STEP_W) begin
        nxt = WIDTH'(cur_w - STEP_W);
      end else begin
        crossed = 1'b1;
`ifdef ADDR_COUNTER_SAT_EN
        nxt = '0;
`else
        nxt = WIDTH'(cur_w + MOD_W - STEP_W);
`endif
      end
    end
  end

endmodule

// File: rtl/addr_counter.sv
// Parametrised up/down address counter with load, enable and registered
// status flags (wrap, at_max, at_zero).
// Optional build macro ADDR_COUNTER_SAT_EN selects saturating instead of
// modular behaviour at the range boundary (implemented in addr_counter_step).
module addr_counter
  import addr_counter_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEFAULT,
  parameter int MAX   = 2**WIDTH - 1,
  parameter int STEP  = STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("addr_counter: WIDTH must be at least 1");
  end
  if (MAX < 1 || (WIDTH < 31 && MAX > (1 << WIDTH) - 1)) begin : g_bad_max
    $error("addr_counter: MAX must satisfy 1 <= MAX <= 2**WIDTH-1");
  end
  if (STEP < 1 || STEP > MAX) begin : g_bad_step
    $error("addr_counter: STEP must satisfy 1 <= STEP <= MAX");
  end

  logic [WIDTH-1:0] step_nxt;
  logic             step_crossed;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] nxt_val;
  logic             nxt_wrap;

  addr_counter_step #(
    .WIDTH (WIDTH),
    .MAX   (MAX),
    .STEP  (STEP)
  ) u_step (
    .cur     (out),
    .up      (up),
    .nxt     (step_nxt),
    .crossed (step_crossed)
  );

  // Out-of-range load values clamp to MAX.
  assign load_clamped = ({1'b0, load_val} > MAX_W) ? WIDTH'(MAX_W) : load_val;

  // Select next count by priority load > en > hold; reset handled at the register.
  always_comb begin
    nxt_val  = out;
    nxt_wrap = 1'b0;
    if (load) begin
      nxt_val = load_clamped;
    end else if (en) begin
      nxt_val  = step_nxt;
      nxt_wrap = step_crossed;
    end
  end

  // Count and flag registers; flags derive from the next value so they track out.
  always_ff @(posedge clk) begin
    if (reset) begin
      out     <= '0;
      wrap    <= 1'b0;
      at_max  <= (MAX == 0);
      at_zero <= 1'b1;
    end else begin
      out     <= nxt_val;
      wrap    <= nxt_wrap;
      at_max  <= (nxt_val == WIDTH'(MAX_W));
      at_zero <= (nxt_val == '0);
    end
  end

endmodule

// File: tb/tb_addr_counter.sv
// Bench for addr_counter: two instances (MAX=31/STEP=1 and MAX=19/STEP=3)
// share one stimulus stream and are compared every cycle against an
// arithmetic reference model. Honours ADDR_COUNTER_SAT_EN like the design.
module tb_addr_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_val = '0;

  logic [4:0] out_a, out_b;
  logic       wrap_a, wrap_b, at_max_a, at_max_b, at_zero_a, at_zero_b;

  logic [4:0] outs [2];
  logic       wraps [2];
  logic       maxs_f [2];
  logic       zeros_f [2];

  int checks = 0;
  int errors = 0;

  // Reference model state per instance.
  int mv [2];
  int mw [2];
  int cfg_max  [2] = '{31, 19};
  int cfg_step [2] = '{1, 3};

  always #5 clk = ~clk;

  addr_counter #(.WIDTH(5), .MAX(31), .STEP(1)) u_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out_a), .wrap(wrap_a), .at_max(at_max_a), .at_zero(at_zero_a)
  );

  addr_counter #(.WIDTH(5), .MAX(19), .STEP(3)) u_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out_b), .wrap(wrap_b), .at_max(at_max_b), .at_zero(at_zero_b)
  );

  assign outs[0]    = out_a;
  assign outs[1]    = out_b;
  assign wraps[0]   = wrap_a;
  assign wraps[1]   = wrap_b;
  assign maxs_f[0]  = at_max_a;
  assign maxs_f[1]  = at_max_b;
  assign zeros_f[0] = at_zero_a;
  assign zeros_f[1] = at_zero_b;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: range 0..max treated as integers modulo max+1 (or clipped).
  task automatic model_step(input int i, input bit r, input bit l, input int lv,
                            input bit e, input bit u);
    int m, s;
    m = cfg_max[i];
    s = cfg_step[i];
    mw[i] = 0;
    if (r) begin
      mv[i] = 0;
    end else if (l) begin
      mv[i] = (lv > m) ? m : lv;
    end else if (e) begin
      if (u) begin
        if (mv[i] + s > m) mw[i] = 1;
`ifdef ADDR_COUNTER_SAT_EN
        mv[i] = (mv[i] + s > m) ? m : mv[i] + s;
`else
        mv[i] = (mv[i] + s) % (m + 1);
`endif
      end else begin
        if (mv[i] < s) mw[i] = 1;
`ifdef ADDR_COUNTER_SAT_EN
        mv[i] = (mv[i] < s) ? 0 : mv[i] - s;
`else
        mv[i] = (mv[i] - s + m + 1) % (m + 1);
`endif
      end
    end
  endtask

  task automatic cyc(input bit r, input bit l, input int lv, input bit e, input bit u);
    reset    = r;
    load     = l;
    load_val = 5'(lv);
    en       = e;
    up       = u;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, r, l, lv, e, u);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out[%0d]", i), {27'd0, outs[i]}, mv[i]);
      chk($sformatf("wrap[%0d]", i), {31'd0, wraps[i]}, mw[i]);
      chk($sformatf("at_max[%0d]", i), {31'd0, maxs_f[i]}, int'(mv[i] == cfg_max[i]));
      chk($sformatf("at_zero[%0d]", i), {31'd0, zeros_f[i]}, int'(mv[i] == 0));
    end
  endtask

  initial begin
    mv = '{0, 0};
    mw = '{0, 0};
    @(negedge clk);

    // Reset state.
    cyc(1, 0, 0, 0, 0);
    chk("reset_out_a", {27'd0, out_a}, 0);
    chk("reset_zero_a", {31'd0, at_zero_a}, 1);

    // Free-running up count across the top of the range.
    for (int k = 0; k < 34; k++) cyc(0, 0, 0, 1, 1);

    // Load 18 then step up (wraps in u_b), then down across zero.
    cyc(0, 1, 18, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);

    // Out-of-range load clamps; load beats enable.
    cyc(0, 1, 25, 0, 0);
    chk("clamp_out_b", {27'd0, out_b}, 19);
    chk("clamp_max_b", {31'd0, at_max_b}, 1);
    cyc(0, 1, 5, 1, 1);
    chk("load_wins_a", {27'd0, out_a}, 5);

    // Reset mid-count, then resume.
    cyc(0, 1, 9, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 1);

    // Hold, then direction toggling every cycle.
    cyc(0, 1, 7, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, (k % 2) == 0);

    // Boundary behaviour at top and bottom.
    cyc(0, 1, 30, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 1, 0, 0);
    for (int k = 0; k < 2; k++) cyc(0, 0, 0, 1, 0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 31)), $urandom_range(0, 4) != 0,
          $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
